// File: rtl/vga_char_pkg.sv
// Shared constants and types for the VGA character write scheduler.
//   CHAR_W       character code width
//   SCREEN_COLS  text columns, SCREEN_ROWS text rows
//   DEF_CELLS    default number of screen cells covered by a fill
//   sched_state_e  scheduler state: IDLE (requesters arbitrated) / FILL
package vga_char_pkg;
  localparam int CHAR_W      = 8;
  localparam int SCREEN_COLS = 80;
  localparam int SCREEN_ROWS = 30;
  localparam int DEF_CELLS   = SCREEN_COLS * SCREEN_ROWS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } sched_state_e;
endpackage

// File: rtl/vga_char_write_sched_if.sv
// Requester bus plus the single character-RAM write port.
//   req_valid_i / req_char_i / req_addr_i : per-requester write, packed by index
//   req_ready_o                           : one-hot grant back to requesters
//   char_o / addr_o / wen_o               : write port into vgachargen_wrapper
// master = requester/port side, slave = scheduler side.
interface vga_char_write_sched_if
  import vga_char_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 13
);
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ*CHAR_W-1:0] req_char_i;
  logic [NREQ*ADDR_W-1:0] req_addr_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [CHAR_W-1:0]      char_o;
  logic [ADDR_W-1:0]      addr_o;
  logic                   wen_o;

  modport master (
    output req_valid_i, req_char_i, req_addr_i,
    input  req_ready_o, char_o, addr_o, wen_o
  );
  modport slave (
    input  req_valid_i, req_char_i, req_addr_i,
    output req_ready_o, char_o, addr_o, wen_o
  );
endinterface

// File: rtl/vga_char_rr_arb.sv
// NREQ-wide round-robin arbiter.
//   clk_i, rstn_i : clock, async active-low reset
//   req_i         : request vector
//   advance_i     : a grant was consumed this cycle; move the pointer past it
//   gnt_o         : one-hot grant (combinational)
// The pointer holds the first index searched; it resets to 0 and moves to
// (winner+1) mod NREQ only when advance_i is set.
module vga_char_rr_arb #(
  parameter int NREQ = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] gnt_o
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d, gidx;
  logic          found;

  // Two passes instead of a modulo: indices >= ptr first, then the wrap.
  always_comb begin
    gnt_o = '0;
    gidx  = ptr_q;
    found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req_i[j] && (j >= int'(ptr_q))) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        gidx     = PW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req_i[j] && (j < int'(ptr_q))) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        gidx     = PW'(j);
      end
    end
    ptr_d = ptr_q;
    if (advance_i && found)
      ptr_d = (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
endmodule

// File: rtl/vga_char_write_sched.sv
// Character write scheduler: sole driver of the vgachargen_wrapper write port.
//   clk_i, rstn_i  : clock, async active-low reset
//   bus            : requester handshake + write port (vga_char_write_sched_if.slave)
//   fill_start_i   : pulse, start a screen fill (IDLE only)
//   fill_char_i    : fill character, sampled with an accepted fill_start_i
//   fill_busy_o    : fill in progress
//   fill_done_o    : one-cycle pulse the cycle after the last fill write
// Optional feature macro: VGA_CHAR_FILL_EN enables the screen-fill sequencer.
// Without it the FSM never leaves IDLE and the fill outputs stay 0.
module vga_char_write_sched
  import vga_char_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 13,
  parameter int CELLS  = DEF_CELLS
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  vga_char_write_sched_if.slave bus,
  input  logic               fill_start_i,
  input  logic [CHAR_W-1:0]  fill_char_i,
  output logic               fill_busy_o,
  output logic               fill_done_o
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

  sched_state_e      state_q;
  logic [CHAR_W-1:0] char_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q, busy_q, done_q;

  logic [NREQ-1:0]   arb_req, gnt;
  logic              fill_go, xfer;
  logic [CHAR_W-1:0] sel_char;
  logic [ADDR_W-1:0] sel_addr;

`ifdef VGA_CHAR_FILL_EN
  assign fill_go = (state_q == IDLE) && fill_start_i;
`else
  assign fill_go = 1'b0;
  logic unused_fill;
  assign unused_fill = ^{fill_start_i, fill_char_i};
`endif

  // Requesters see no grant while the fill owns the port or is being started.
  assign arb_req = ((state_q == IDLE) && !fill_go) ? bus.req_valid_i : '0;
  assign xfer    = |gnt;

  vga_char_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .req_i     (arb_req),
    .advance_i (xfer),
    .gnt_o     (gnt)
  );

  always_comb begin
    sel_char = '0;
    sel_addr = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt[j]) begin
        sel_char = bus.req_char_i[CHAR_W*j +: CHAR_W];
        sel_addr = bus.req_addr_i[ADDR_W*j +: ADDR_W];
      end
    end
  end

  // addr_q doubles as the fill counter: during FILL it always holds the
  // address currently on the port, and char_q holds the latched fill char.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      char_q  <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fill_go) begin
            // first fill write goes out on the very next cycle
            state_q <= FILL;
            busy_q  <= 1'b1;
            char_q  <= fill_char_i;
            addr_q  <= '0;
            wen_q   <= 1'b1;
          end else if (xfer) begin
            char_q <= sel_char;
            addr_q <= sel_addr;
            wen_q  <= 1'b1;
          end
        end
        FILL: begin
          if (addr_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            addr_q <= addr_q + 1'b1;
            wen_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = gnt;
  assign bus.char_o      = char_q;
  assign bus.addr_o      = addr_q;
  assign bus.wen_o       = wen_q;
  assign fill_busy_o     = busy_q;
  assign fill_done_o     = done_q;
endmodule

// File: tb/tb_vga_char_write_sched.sv
module tb_vga_char_write_sched;
  localparam int NREQ   = 2;
  localparam int ADDR_W = 13;
  localparam int CELLS  = 2400;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       fill_start_i = 1'b0;
  logic [7:0] fill_char_i = 8'h00;
  logic       fill_busy_o, fill_done_o;

  vga_char_write_sched_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) bus();

  vga_char_write_sched #(.NREQ(NREQ), .ADDR_W(ADDR_W), .CELLS(CELLS)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .bus          (bus),
    .fill_start_i (fill_start_i),
    .fill_char_i  (fill_char_i),
    .fill_busy_o  (fill_busy_o),
    .fill_done_o  (fill_done_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [7:0]  c0;
    logic [12:0] a0;
    logic [7:0]  c1;
    logic [12:0] a1;
    logic [1:0]  rdy;
    logic        wen;
    logic [7:0]  ch;
    logic [12:0] ad;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] c0, input logic [12:0] a0,
                       input logic [7:0] c1, input logic [12:0] a1);
    bus.req_valid_i = v;
    bus.req_char_i  = {c1, c0};
    bus.req_addr_i  = {a1, a0};
  endtask

  task automatic do_reset();
    drive(2'b00, 8'h0, 13'h0, 8'h0, 13'h0);
    fill_start_i = 1'b0;
    fill_char_i  = 8'h00;
    rstn_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  initial begin
    int n, errs;
    // valid, c0, a0, c1, a1 | ready, wen(next), char(next), addr(next)
    vecs[0] = '{2'b01, 8'h41, 13'd5,    8'h00, 13'd0,    2'b01, 1'b1, 8'h41, 13'd5};
    vecs[1] = '{2'b11, 8'h42, 13'd6,    8'h61, 13'd100,  2'b10, 1'b1, 8'h61, 13'd100};
    vecs[2] = '{2'b11, 8'h43, 13'd7,    8'h62, 13'd101,  2'b01, 1'b1, 8'h43, 13'd7};
    vecs[3] = '{2'b11, 8'h43, 13'd7,    8'h62, 13'd101,  2'b10, 1'b1, 8'h62, 13'd101};
    vecs[4] = '{2'b00, 8'h99, 13'd9,    8'h98, 13'd9,    2'b00, 1'b0, 8'h62, 13'd101};
    vecs[5] = '{2'b10, 8'h00, 13'd0,    8'h63, 13'd8191, 2'b10, 1'b1, 8'h63, 13'd8191};
    vecs[6] = '{2'b10, 8'h00, 13'd0,    8'h64, 13'd0,    2'b10, 1'b1, 8'h64, 13'd0};
    vecs[7] = '{2'b01, 8'hFF, 13'd4095, 8'h00, 13'd0,    2'b01, 1'b1, 8'hFF, 13'd4095};
    vecs[8] = '{2'b01, 8'h00, 13'd1,    8'h00, 13'd0,    2'b01, 1'b1, 8'h00, 13'd1};
    vecs[9] = '{2'b11, 8'h10, 13'd2,    8'h20, 13'd3,    2'b10, 1'b1, 8'h20, 13'd3};

    do_reset();
    check("rst_char", bus.char_o, 8'h00);
    check("rst_addr", bus.addr_o, 13'd0);
    check("rst_wen",  bus.wen_o, 1'b0);
    check("rst_ready", bus.req_ready_o, 2'b00);
    check("rst_busy", fill_busy_o, 1'b0);
    check("rst_done", fill_done_o, 1'b0);

    // table-driven arbitration and datapath vectors
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].c0, vecs[i].a0, vecs[i].c1, vecs[i].a1);
      #1;
      check($sformatf("vec%0d_ready", i), bus.req_ready_o, vecs[i].rdy);
      tick();
      check($sformatf("vec%0d_wen", i),  bus.wen_o,  vecs[i].wen);
      check($sformatf("vec%0d_char", i), bus.char_o, vecs[i].ch);
      check($sformatf("vec%0d_addr", i), bus.addr_o, vecs[i].ad);
    end

    // contention from reset: 0,1,0,1,... with a write every cycle
    do_reset();
    drive(2'b11, 8'hA0, 13'd10, 8'hB0, 13'd20);
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("cont%0d_ready", k), bus.req_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check($sformatf("cont%0d_wen", k), bus.wen_o, 1'b1);
      check($sformatf("cont%0d_addr", k), bus.addr_o, (k % 2 == 0) ? 13'd10 : 13'd20);
    end

`ifdef VGA_CHAR_FILL_EN
    // fill with a competing requester and a mid-fill restart attempt
    do_reset();
    drive(2'b01, 8'h41, 13'd5, 8'h00, 13'd0);
    fill_start_i = 1'b1;
    fill_char_i  = 8'h20;
    #1;
    check("fill_start_ready", bus.req_ready_o, 2'b00);
    tick();
    fill_start_i = 1'b0;
    fill_char_i  = 8'hAA;
    n = 0;
    errs = 0;
    while (bus.wen_o === 1'b1 && n < CELLS + 10) begin
      if (bus.addr_o !== 13'(n) || bus.char_o !== 8'h20 || bus.req_ready_o !== 2'b00 ||
          fill_busy_o !== 1'b1 || fill_done_o !== 1'b0) begin
        if (errs == 0)
          $display("FAIL fill_write%0d: addr %0d char %0h rdy %0b busy %0b done %0b",
                   n, bus.addr_o, bus.char_o, bus.req_ready_o, fill_busy_o, fill_done_o);
        errs++;
      end
      fill_start_i = (n == 1000);
      fill_char_i  = (n == 1000) ? 8'h55 : 8'hAA;
      n++;
      tick();
    end
    fill_start_i = 1'b0;
    check("fill_seq_errs", errs, 0);
    check("fill_count", n, CELLS);
    check("fill_done", fill_done_o, 1'b1);
    check("fill_done_busy", fill_busy_o, 1'b0);
    check("fill_done_wen", bus.wen_o, 1'b0);
    check("fill_done_ready", bus.req_ready_o, 2'b01);
    tick();
    check("post_fill_wen", bus.wen_o, 1'b1);
    check("post_fill_char", bus.char_o, 8'h41);
    check("post_fill_addr", bus.addr_o, 13'd5);
    check("post_fill_done", fill_done_o, 1'b0);
    drive(2'b00, 8'h0, 13'h0, 8'h0, 13'h0);

    // async reset in the middle of a fill
    tick();
    fill_start_i = 1'b1;
    fill_char_i  = 8'h2A;
    tick();
    fill_start_i = 1'b0;
    n = 0;
    while (bus.addr_o !== 13'd1000 && n < 3000) begin
      n++;
      tick();
    end
    check("mid_fill_reached", bus.addr_o, 13'd1000);
    #2;
    rstn_i = 1'b0;
    #1;
    check("midrst_wen", bus.wen_o, 1'b0);
    check("midrst_addr", bus.addr_o, 13'd0);
    check("midrst_char", bus.char_o, 8'h00);
    check("midrst_busy", fill_busy_o, 1'b0);
    check("midrst_done", fill_done_o, 1'b0);
    drive(2'b11, 8'h71, 13'd77, 8'h72, 13'd78);
    errs = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (fill_done_o !== 1'b0) errs++;
    end
    #1;
    rstn_i = 1'b1;
    #1;
    check("after_rst_ready", bus.req_ready_o, 2'b01);
    tick();
    check("after_rst_wen", bus.wen_o, 1'b1);
    check("after_rst_char", bus.char_o, 8'h71);
    repeat (3) begin
      if (fill_done_o !== 1'b0 || fill_busy_o !== 1'b0) errs++;
      tick();
    end
    check("after_rst_no_done", errs, 0);
`else
    // fill disabled: start pulses must not touch the port
    do_reset();
    fill_start_i = 1'b1;
    fill_char_i  = 8'h20;
    tick();
    fill_start_i = 1'b0;
    check("nofill_wen", bus.wen_o, 1'b0);
    check("nofill_busy", fill_busy_o, 1'b0);
    check("nofill_done", fill_done_o, 1'b0);
    errs = 0;
    repeat (4) begin
      if (bus.wen_o !== 1'b0 || fill_busy_o !== 1'b0 || fill_done_o !== 1'b0) errs++;
      tick();
    end
    check("nofill_quiet", errs, 0);
    drive(2'b01, 8'h41, 13'd5, 8'h00, 13'd0);
    fill_start_i = 1'b1;
    #1;
    check("nofill_ready", bus.req_ready_o, 2'b01);
    tick();
    fill_start_i = 1'b0;
    check("nofill_req_wen", bus.wen_o, 1'b1);
    check("nofill_req_char", bus.char_o, 8'h41);
    check("nofill_req_addr", bus.addr_o, 13'd5);
    check("nofill_req_busy", fill_busy_o, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
